hc_down_timer: RTL and testbench

- Presettable, cascadable synchronous down-counter/timer. It is the counting-down counterpart of the team's HC161-based up counter.
- It loads a start value, counts toward zero, and flags terminal count (borrow) on TC.
- It supports one-shot and auto-reload modes, so it can act as a programmable delay or a divide-by-(N+1) tick source alongside the up counter.

---
 rtl/hc_timer_pkg.sv | 11 +
 rtl/hc_down_cnt.sv | 35 +++
 rtl/hc_down_timer.sv | 122 ++++++++++++
 tb/tb_hc_down_timer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_timer_pkg.sv
// Shared definitions for the HC-series timer blocks.
package hc_timer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/hc_down_cnt.sv
// Loadable down-counter core: parallel load, decrement that saturates at zero,
// and decoded one/zero flags for the controlling FSM.
module hc_down_cnt
   import hc_timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             MR,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             dec,
   output logic [WIDTH-1:0] Q,
   output logic             is_one,
   output logic             is_zero
);

   // Count register: load has priority, decrement never wraps below zero.
   always_ff @(posedge Clk or posedge MR) begin
      if (MR) begin
         Q <= '0;
      end else if (ld) begin
         Q <= ld_val;
      end else if (dec && !is_zero) begin
         Q <= Q - WIDTH'(1);
      end
   end

   // Terminal-proximity decodes used by the timer FSM.
   always_comb begin
      is_zero = (Q == '0);
      is_one  = (Q == WIDTH'(1));
   end

endmodule

// File: rtl/hc_down_timer.sv
// Presettable down-counter/timer with one-shot and auto-reload modes.
// TC flags the count reaching zero; Done marks the end of a one-shot run.
module hc_down_timer
   import hc_timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             MR,
   input  logic [WIDTH-1:0] D,
   input  logic             Load,
   input  logic             Start,
   input  logic             Stop,
   input  logic             CE,
   input  logic             AutoReload,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             Busy,
   output logic             Done
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] rld;
   logic             rld_load;
   logic             tc_next;
   logic             done_next;
   logic             cnt_ld;
   logic [WIDTH-1:0] cnt_val;
   logic             cnt_dec;
   logic             q_one;
   logic             q_zero;

   hc_down_cnt #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .Clk     (Clk),
      .MR      (MR),
      .ld      (cnt_ld),
      .ld_val  (cnt_val),
      .dec     (cnt_dec),
      .Q       (Q),
      .is_one  (q_one),
      .is_zero (q_zero)
   );

   // State, reload value and the TC/Done pulse flops.
   always_ff @(posedge Clk or posedge MR) begin
      if (MR) begin
         state <= ST_IDLE;
         rld   <= '0;
         TC    <= 1'b0;
         Done  <= 1'b0;
      end else begin
         state <= state_next;
         if (rld_load) begin
            rld <= D;
         end
         TC   <= tc_next;
         Done <= done_next;
      end
   end

   // Busy is a decode of the state flop, so it is glitch-free and registered.
   always_comb begin
      Busy = (state == ST_RUN);
   end

   // Next-state and counter control; priority Load > Stop > Start > count.
   // A Start with Q==0 enters RUN only in auto-reload mode (a zero reload
   // value then yields a TC on every enabled cycle); in one-shot mode it
   // completes immediately with a Done pulse.
   // A zero count reached while running with a non-zero reload value always
   // reloads, so clearing AutoReload only stops the run at the next 1->0 step.
   always_comb begin
      state_next = state;
      tc_next    = 1'b0;
      done_next  = 1'b0;
      rld_load   = 1'b0;
      cnt_ld     = 1'b0;
      cnt_val    = D;
      cnt_dec    = 1'b0;
      if (Load) begin
         cnt_ld     = 1'b1;
         rld_load   = 1'b1;
         state_next = ST_IDLE;
      end else if (Stop) begin
         state_next = ST_IDLE;
      end else if (state == ST_IDLE) begin
         if (Start) begin
            if (!q_zero || AutoReload) begin
               state_next = ST_RUN;
            end else begin
               done_next = 1'b1;
            end
         end
      end else if (CE) begin
         if (q_one) begin
            cnt_dec = 1'b1;
            tc_next = 1'b1;
            if (!AutoReload) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end else if (q_zero) begin
            if (rld == '0) begin
               tc_next = 1'b1;
               if (!AutoReload) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end
            end else begin
               cnt_ld  = 1'b1;
               cnt_val = rld;
            end
         end else begin
            cnt_dec = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hc_down_timer.sv
// Directed bench for hc_down_timer; observations are packed as {Q,TC,Busy,Done}.
module tb_hc_down_timer;

   logic       Clk = 1'b0;
   logic       MR;
   logic [3:0] D;
   logic       Load;
   logic       Start;
   logic       Stop;
   logic       CE;
   logic       AutoReload;
   logic [3:0] Q;
   logic       TC;
   logic       Busy;
   logic       Done;

   int errors = 0;
   int checks = 0;

   hc_down_timer #(
      .WIDTH (4)
   ) dut (
      .Clk        (Clk),
      .MR         (MR),
      .D          (D),
      .Load       (Load),
      .Start      (Start),
      .Stop       (Stop),
      .CE         (CE),
      .AutoReload (AutoReload),
      .Q          (Q),
      .TC         (TC),
      .Busy       (Busy),
      .Done       (Done)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] exp;
      MR = 1'b1; D = '0; Load = 0; Start = 0; Stop = 0; CE = 0; AutoReload = 0;
      #12;
      exp = 7'b0000_000;
      checks++;
      if ({Q, TC, Busy, Done} !== exp) begin
         errors++;
         $display("FAIL reset_state: {Q,TC,Busy,Done} got %b want %b", {Q, TC, Busy, Done}, exp);
      end
      tick();
      MR = 1'b0;
      D = 4'd9; Load = 1;
      tick();
      Load = 0; Start = 1; CE = 1;
      tick();
      Start = 0;
      tick(); tick(); tick();
      exp = {4'd6, 3'b010};
      checks++;
      if ({Q, TC, Busy, Done} !== exp) begin
         errors++;
         $display("FAIL reset_prerun: {Q,TC,Busy,Done} got %b want %b", {Q, TC, Busy, Done}, exp);
      end
      #3 MR = 1'b1;
      #1;
      exp = 7'b0000_000;
      checks++;
      if ({Q, TC, Busy, Done} !== exp) begin
         errors++;
         $display("FAIL reset_async: {Q,TC,Busy,Done} got %b want %b", {Q, TC, Busy, Done}, exp);
      end
      #1 MR = 1'b0;
      CE = 0; Start = 1;
      tick();
      Start = 0;
      exp = {4'd0, 3'b001};
      checks++;
      if ({Q, TC, Busy, Done} !== exp) begin
         errors++;
         $display("FAIL reset_start_zero: {Q,TC,Busy,Done} got %b want %b", {Q, TC, Busy, Done}, exp);
      end
      tick();
      exp = 7'b0000_000;
      checks++;
      if ({Q, TC, Busy, Done} !== exp) begin
         errors++;
         $display("FAIL reset_done_clear: {Q,TC,Busy,Done} got %b want %b", {Q, TC, Busy, Done}, exp);
      end
   endtask

   task automatic test_one_shot();
      logic [6:0] exp;
      logic [6:0] seq [8];
      seq = '{{4'd5, 3'b000}, {4'd5, 3'b010}, {4'd4, 3'b010}, {4'd3, 3'b010},
              {4'd2, 3'b010}, {4'd1, 3'b010}, {4'd0, 3'b101}, {4'd0, 3'b000}};
      D = 4'd5; Load = 1; AutoReload = 0; CE = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         Load  = 0;
         Start = (i == 0);
         exp = seq[i];
         checks++;
         if ({Q, TC, Busy, Done} !== exp) begin
            errors++;
            $display("FAIL one_shot step %0d: {Q,TC,Busy,Done} got %b want %b", i, {Q, TC, Busy, Done}, exp);
         end
      end
      Start = 0; CE = 0;
   endtask

   task automatic test_auto_reload();
      logic [6:0] exp;
      logic [3:0] qtab [12];
      qtab = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
      D = 4'd3; Load = 1; AutoReload = 1; CE = 1;
      tick();
      Load = 0; Start = 1;
      tick();
      Start = 0;
      exp = {4'd3, 3'b010};
      checks++;
      if ({Q, TC, Busy, Done} !== exp) begin
         errors++;
         $display("FAIL auto_start: {Q,TC,Busy,Done} got %b want %b", {Q, TC, Busy, Done}, exp);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         exp = {qtab[i], (qtab[i] == 4'd0), 1'b1, 1'b0};
         checks++;
         if ({Q, TC, Busy, Done} !== exp) begin
            errors++;
            $display("FAIL auto_reload cycle %0d: {Q,TC,Busy,Done} got %b want %b", i, {Q, TC, Busy, Done}, exp);
         end
      end
      Stop = 1;
      tick();
      Stop = 0; CE = 0; AutoReload = 0;
      exp = {4'd3, 3'b000};
      checks++;
      if ({Q, TC, Busy, Done} !== exp) begin
         errors++;
         $display("FAIL auto_stop: {Q,TC,Busy,Done} got %b want %b", {Q, TC, Busy, Done}, exp);
      end
   endtask

   task automatic test_ce_stop();
      logic [6:0] exp;
      logic [6:0] seq [8];
      logic       ce_tab [8];
      logic       stop_tab [8];
      seq      = '{{4'd4, 3'b000}, {4'd4, 3'b010}, {4'd3, 3'b010}, {4'd2, 3'b010},
                   {4'd2, 3'b010}, {4'd2, 3'b010}, {4'd1, 3'b010}, {4'd1, 3'b000}};
      ce_tab   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      stop_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      D = 4'd4; Load = 1; AutoReload = 0; CE = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         Load  = 0;
         Start = (i == 0);
         CE    = ce_tab[i];
         Stop  = stop_tab[i];
         exp = seq[i];
         checks++;
         if ({Q, TC, Busy, Done} !== exp) begin
            errors++;
            $display("FAIL ce_stop step %0d: {Q,TC,Busy,Done} got %b want %b", i, {Q, TC, Busy, Done}, exp);
         end
      end
      Stop = 0; CE = 0; Start = 0;
   endtask

   task automatic test_priority();
      logic [6:0] exp;
      logic [6:0] seq [5];
      seq = '{{4'd7, 3'b000}, {4'd7, 3'b010}, {4'd6, 3'b010}, {4'd2, 3'b000}, {4'd2, 3'b000}};
      D = 4'd7; Load = 1; Start = 1; CE = 1; AutoReload = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         Load  = (i == 2);
         Start = (i == 0);
         D     = (i == 2) ? 4'd2 : D;
         exp = seq[i];
         checks++;
         if ({Q, TC, Busy, Done} !== exp) begin
            errors++;
            $display("FAIL priority step %0d: {Q,TC,Busy,Done} got %b want %b", i, {Q, TC, Busy, Done}, exp);
         end
      end
      Load = 0; Start = 0; CE = 0;
   endtask

   task automatic test_zero();
      logic [6:0] exp;
      logic [6:0] seq [9];
      seq = '{{4'd0, 3'b000}, {4'd0, 3'b001}, {4'd0, 3'b000}, {4'd0, 3'b010}, {4'd0, 3'b110},
              {4'd0, 3'b110}, {4'd0, 3'b110}, {4'd0, 3'b010}, {4'd0, 3'b000}};
      D = 4'd0; Load = 1; AutoReload = 0; CE = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         Load       = 0;
         Start      = (i == 0) || (i == 2);
         AutoReload = (i >= 2);
         CE         = (i >= 3) && (i <= 5);
         Stop       = (i == 7);
         exp = seq[i];
         checks++;
         if ({Q, TC, Busy, Done} !== exp) begin
            errors++;
            $display("FAIL zero step %0d: {Q,TC,Busy,Done} got %b want %b", i, {Q, TC, Busy, Done}, exp);
         end
      end
      Start = 0; Stop = 0; CE = 0; AutoReload = 0;
   endtask

   task automatic test_ar_clear();
      logic [6:0] exp;
      logic [6:0] seq [7];
      seq = '{{4'd2, 3'b000}, {4'd2, 3'b010}, {4'd1, 3'b010}, {4'd0, 3'b110},
              {4'd2, 3'b010}, {4'd1, 3'b010}, {4'd0, 3'b101}};
      D = 4'd2; Load = 1; AutoReload = 1; CE = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         Load       = 0;
         Start      = (i == 0);
         AutoReload = (i < 3);
         exp = seq[i];
         checks++;
         if ({Q, TC, Busy, Done} !== exp) begin
            errors++;
            $display("FAIL ar_clear step %0d: {Q,TC,Busy,Done} got %b want %b", i, {Q, TC, Busy, Done}, exp);
         end
      end
      Start = 0; CE = 0;
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_ce_stop();
      test_priority();
      test_zero();
      test_ar_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
